// File: rtl/tinyalu_pkg.sv
// rtl/tinyalu_pkg.sv - TinyALU opcode, state and width definitions
package tinyalu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ALU  = 2'd1,
        MUL  = 2'd2
    } alu_state_t;

    localparam int RESULT_W = 16;

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// rtl/tinyalu_mul_pipe.sv - registered 8x8 unsigned multiplier with valid shift chain
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          a,
    input  logic [7:0]          b,
    input  logic                valid_in,
    output logic [RESULT_W-1:0] prod,
    output logic                valid_out
);

    logic [RESULT_W-1:0] prod_q [STAGES];
    logic [STAGES-1:0]   vld_q;

    // Valid chain; cleared by reset so an aborted multiply never reports completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_in;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Product is formed in the first stage and then only delayed to match the valid chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            prod_q[0] <= {8'b0, a} * {8'b0, b};
            for (int i = 1; i < STAGES; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign prod      = prod_q[STAGES-1];
    assign valid_out = vld_q[STAGES-1];

endmodule

// File: rtl/tinyalu_core.sv
// rtl/tinyalu_core.sv - TinyALU datapath with start/done handshake
module tinyalu_core
    import tinyalu_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          A,
    input  logic [7:0]          B,
    input  operation_t          op,
    input  logic                start,
    output logic                done,
    output logic [RESULT_W-1:0] result,
    output logic                busy
);

    localparam logic [2:0] MUL_LOAD = 3'(MUL_CYCLES - 1);

    alu_state_t          state, state_next;
    logic                start_q;
    logic [7:0]          a_q, b_q;
    operation_t          op_q;
    logic [2:0]          mul_cnt;
    logic                accept;
    logic                mul_valid_in;
    logic                mul_valid;
    logic [RESULT_W-1:0] mul_prod;

    // Only a fresh rise of start in IDLE is a command; rises while busy are dropped.
    assign accept       = (state == IDLE) && start && !start_q;
    assign busy         = (state != IDLE);
    // The pipe is launched once, in the first cycle after entering MUL.
    assign mul_valid_in = (state == MUL) && (mul_cnt == MUL_LOAD);

    tinyalu_mul_pipe #(
        .STAGES (MUL_CYCLES - 1)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .a         (a_q),
        .b         (b_q),
        .valid_in  (mul_valid_in),
        .prod      (mul_prod),
        .valid_out (mul_valid)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: ALU ops finish one edge after acceptance, MUL waits for the pipe.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (op == mul_op) ? MUL : ALU;
            ALU:  state_next = IDLE;
            MUL:  if (mul_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, MUL counter, result register and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= no_op;
            mul_cnt <= '0;
            result  <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            if (accept) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
                if (op == mul_op) mul_cnt <= MUL_LOAD;
            end
            if (state == MUL) begin
                if (mul_valid) mul_cnt <= '0;
                else if (mul_cnt != 3'd0) mul_cnt <= mul_cnt - 3'd1;
            end
            if (state == ALU) begin
                done <= 1'b1;
                case (op_q)
                    add_op:  result <= {7'b0, {1'b0, a_q} + {1'b0, b_q}};
                    and_op:  result <= {8'b0, a_q & b_q};
                    xor_op:  result <= {8'b0, a_q ^ b_q};
                    rst_op:  result <= '0;
                    default: result <= result;
                endcase
            end
            if ((state == MUL) && mul_valid) begin
                done   <= 1'b1;
                result <= mul_prod;
            end
        end
    end

endmodule

// File: tb/tb_tinyalu_core.sv
// tb/tb_tinyalu_core.sv - scoreboard testbench for tinyalu_core
module tb_tinyalu_core;
    import tinyalu_pkg::*;

    localparam int MUL_CYCLES = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    operation_t  op = no_op;
    logic        start = 1'b0;
    logic        done;
    logic [15:0] result;
    logic        busy;

    tinyalu_core #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .op     (op),
        .start  (start),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] res;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          pushed = 0;
    int          done_cnt = 0;
    logic [15:0] model_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_result(input operation_t o, input logic [7:0] a,
                                               input logic [7:0] b, input logic [15:0] prev);
        case (o)
            add_op:  return 16'(a) + 16'(b);
            and_op:  return 16'(a & b);
            xor_op:  return 16'(a ^ b);
            mul_op:  return 16'(a) * 16'(b);
            rst_op:  return 16'h0000;
            default: return prev;
        endcase
    endfunction

    function automatic int lat(input operation_t o);
        return (o == mul_op) ? MUL_CYCLES : 1;
    endfunction

    task automatic expect_cmd(input operation_t o, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        model_res = ref_result(o, a, b, model_res);
        e.res = model_res;
        e.due = cyc + 1 + lat(o);
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("done_cycle", cyc, e.due);
            end
        end
    end

    task automatic issue(input operation_t o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        expect_cmd(o, a, b);
        @(negedge clk);
        start = 1'b0;
        A = ~a; B = ~b; op = operation_t'(3'($urandom_range(0, 7)));
        check("busy_after_accept", busy, 1);
        repeat (lat(o)) @(negedge clk);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_done", done, 0);
        check("reset_result", result, 16'h0000);
        check("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Directed commands
        issue(add_op, 8'hFF, 8'hFF);
        issue(mul_op, 8'hFF, 8'hFF);
        issue(and_op, 8'hF0, 8'h3C);
        issue(xor_op, 8'hF0, 8'h3C);
        issue(no_op,  8'h55, 8'hAA);
        issue(rst_op, 8'h12, 8'h34);
        issue(operation_t'(3'b101), 8'h01, 8'h02);

        // start held high after done must not retrigger
        @(negedge clk);
        A = 8'h12; B = 8'h34; op = add_op; start = 1'b1;
        expect_cmd(add_op, 8'h12, 8'h34);
        repeat (12) @(negedge clk);
        check("held_start_busy", busy, 0);
        start = 1'b0;
        @(negedge clk);
        issue(add_op, 8'h80, 8'h80);

        // Reset two cycles into a multiply aborts it
        @(negedge clk);
        A = 8'h10; B = 8'h10; op = mul_op; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_result", result, 16'h0000);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        model_res = '0;
        A = 8'h03; B = 8'h04; op = add_op;
        @(negedge clk);
        reset = 1'b0;
        expect_cmd(add_op, 8'h03, 8'h04);
        @(negedge clk);
        check("release_accept_busy", busy, 1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Start pulse while busy during a multiply is ignored
        @(negedge clk);
        A = 8'h0F; B = 8'h11; op = mul_op; start = 1'b1;
        expect_cmd(mul_op, 8'h0F, 8'h11);
        @(negedge clk);
        start = 1'b0; A = 8'h00; B = 8'h00;
        @(negedge clk);
        start = 1'b1; op = add_op;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_pulse_idle", busy, 0);

        // Randomized commands across all opcodes including reserved codes
        for (int i = 0; i < 40; i++) begin
            issue(operation_t'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom));
        end

        repeat (MUL_CYCLES + 4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", done_cnt, pushed);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
